// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the AD9248 acquisition scheduler.
// Holds the FSM state encoding and the averaging-exponent clamp.
package adc_acq_pkg;

  localparam int DW_DEFAULT       = 14;
  localparam int MAX_LOG2_DEFAULT = 5;
  localparam int ACC_W            = DW_DEFAULT + MAX_LOG2_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_OUT
  } state_t;

  function automatic logic [2:0] clamp_log2(input logic [2:0] log2,
                                            input logic [2:0] max_log2);
    return (log2 > max_log2) ? max_log2 : log2;
  endfunction

endpackage

// File: rtl/adc_rr_arb2.sv
// Two-requester round-robin arbiter: on a tie the requester that did not
// win last time is granted; a lone requester is always granted.
module adc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       id
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt = 2'b00;
    id  = 1'b0;
    if (enable) begin
      case (req)
        2'b01: begin
          gnt = 2'b01;
          id  = 1'b0;
        end
        2'b10: begin
          gnt = 2'b10;
          id  = 1'b1;
        end
        2'b11: begin
          id  = ~rr_last;
          gnt = rr_last ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adc_acq_sched.sv
// Shares the AD9248 sample stream between two requesters: grants round-robin,
// drops settling samples, accumulates 2^log2 samples and returns the average.
module adc_acq_sched
  import adc_acq_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int SETTLE   = 4,
  parameter int MAX_LOG2 = MAX_LOG2_DEFAULT
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data_a,
  input  logic [DW-1:0] adc_data_b,
  input  logic [1:0]    req,
  input  logic          req0_ch,
  input  logic [2:0]    req0_log2,
  input  logic          req1_ch,
  input  logic [2:0]    req1_log2,
  input  logic          abort,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          result_valid,
  output logic          result_id,
  output logic          result_ch,
  output logic [DW-1:0] result_data
);

  localparam int         AW    = DW + MAX_LOG2;
  localparam int         CW    = (MAX_LOG2 + 1 > 4) ? MAX_LOG2 + 1 : 4;
  localparam logic [2:0] MAX_L = 3'(MAX_LOG2);

  state_t          state;
  logic            rr_last;
  logic            sel_id;
  logic            sel_ch;
  logic [2:0]      sel_log2;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic [1:0]      arb_gnt;
  logic            arb_id;
  logic [DW-1:0]   sample;
  logic [AW-1:0]   acc_sum;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   acc_tgt;

  // Grants only in IDLE and never while reset is asserted.
  adc_rr_arb2 u_arb (
    .req     (req),
    .rr_last (rr_last),
    .enable  (state == ST_IDLE && !sys_rst),
    .gnt     (arb_gnt),
    .id      (arb_id)
  );

  assign gnt     = arb_gnt;
  assign busy    = (state != ST_IDLE);
  assign sample  = sel_ch ? adc_data_b : adc_data_a;
  assign acc_sum = acc + AW'(sample);
  assign cnt_inc = cnt + CW'(1);
  assign acc_tgt = CW'(1) << sel_log2;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      rr_last      <= 1'b1;
      sel_id       <= 1'b0;
      sel_ch       <= 1'b0;
      sel_log2     <= '0;
      acc          <= '0;
      cnt          <= '0;
      result_valid <= 1'b0;
      result_id    <= 1'b0;
      result_ch    <= 1'b0;
      result_data  <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|arb_gnt) begin
            rr_last  <= arb_id;
            sel_id   <= arb_id;
            sel_ch   <= arb_id ? req1_ch : req0_ch;
            sel_log2 <= clamp_log2(arb_id ? req1_log2 : req0_log2, MAX_L);
            acc      <= '0;
            cnt      <= '0;
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (adc_valid) begin
            if (cnt_inc == CW'(SETTLE)) begin
              cnt   <= '0;
              state <= ST_ACCUM;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_ACCUM: begin
          // abort outranks the final strobe: no result is produced.
          if (abort) begin
            state <= ST_IDLE;
          end else if (adc_valid) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
            if (cnt_inc == acc_tgt) begin
              state        <= ST_OUT;
              result_valid <= 1'b1;
              result_data  <= DW'(acc_sum >> sel_log2);
              result_id    <= sel_id;
              result_ch    <= sel_ch;
            end
          end
        end
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
